// File: rtl/dac_ad56x3_spi_pkg.sv
// Shared constants, state encoding and frame packing for the AD56x3 SPI writer.
package dacAd56x3Pkg;

  localparam int FRAME_BITS = 24;

  // AD56x3 command field values
  localparam logic [2:0] CMD_WR_N       = 3'b000;
  localparam logic [2:0] CMD_WR_UPD_ALL = 3'b010;
  localparam logic [2:0] CMD_WR_UPD_N   = 3'b011;

  // AD56x3 address field values
  localparam logic [2:0] ADDR_A = 3'b000;
  localparam logic [2:0] ADDR_B = 3'b001;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  // Pack command, address and left-aligned 16-bit value into one write frame.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [2:0]  cmd,
                                                        input logic [2:0]  addr,
                                                        input logic [15:0] val);
    return {2'b00, cmd, addr, val};
  endfunction

endpackage

// File: rtl/dac_ad56x3_sclk_timer.sv
// SCLK phase timer: half-period counter plus bit counter, emitting fall/rise/last strobes.
module dac_ad56x3_sclk_timer
  import dacAd56x3Pkg::*;
#(
  parameter int SCLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic fall,
  output logic rise,
  output logic last
);

  localparam int HW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic [HW-1:0] half_cnt;
  logic          low_phase;
  logic [4:0]    bit_cnt;
  logic          tick;

  // A half-period ends when the counter reaches SCLK_DIV-1; the phase bit decides fall vs rise.
  assign tick = run && (half_cnt == HW'(SCLK_DIV - 1));
  assign fall = tick && !low_phase;
  assign rise = tick && low_phase;
  assign last = rise && (bit_cnt == 5'(FRAME_BITS - 1));

  // Advance the half-period counter, toggle phase, count completed SCLK periods.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      half_cnt  <= '0;
      low_phase <= 1'b0;
      bit_cnt   <= '0;
    end else if (start) begin
      half_cnt  <= '0;
      low_phase <= 1'b0;
      bit_cnt   <= '0;
    end else if (run) begin
      if (tick) begin
        half_cnt  <= '0;
        low_phase <= !low_phase;
        if (low_phase) bit_cnt <= bit_cnt + 5'd1;
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_ad56x3_spi.sv
// Avalon-ST sink that serialises each accepted sample as a 24-bit AD56x3 write frame.
module dac_ad56x3_spi
  import dacAd56x3Pkg::*;
#(
  parameter int DATA_WIDTH    = 14,
  parameter int SCLK_DIV      = 2,
  parameter int GAP_CYCLES    = 2,
  parameter int SIMULT_UPDATE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  asiValid,
  input  logic                  asiChannel,
  input  logic [DATA_WIDTH-1:0] asiData,
  output logic                  asiRdy,
  output logic                  syncN,
  output logic                  sclk,
  output logic                  din
);

  localparam int DATA_SHIFT = 16 - DATA_WIDTH;
  localparam int GW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  if (!(DATA_WIDTH == 12 || DATA_WIDTH == 14 || DATA_WIDTH == 16)) begin : g_bad_width
    $error("dac_ad56x3_spi: DATA_WIDTH must be 12, 14 or 16");
  end
  if (SCLK_DIV < 1) begin : g_bad_div
    $error("dac_ad56x3_spi: SCLK_DIV must be at least 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("dac_ad56x3_spi: GAP_CYCLES must be at least 1");
  end

  state_t                state, state_nxt;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] frame_word;
  logic [GW-1:0]         gap_cnt;
  logic [2:0]            cmd;
  logic [2:0]            addr;
  logic [15:0]           sample_al;
  logic                  accept;
  logic                  fall, rise, last;
  logic                  load, shift;
  logic                  sync_nxt, sclk_nxt, din_nxt, rdy_nxt;

  assign accept = asiValid && asiRdy;

  // ch1 in simultaneous mode refreshes both outputs, so ch0 only loads its input register.
  assign cmd = (SIMULT_UPDATE != 0) ? (asiChannel ? CMD_WR_UPD_ALL : CMD_WR_N) : CMD_WR_UPD_N;
  assign addr       = asiChannel ? ADDR_B : ADDR_A;
  assign sample_al  = 16'(asiData) << DATA_SHIFT;
  assign frame_word = build_frame(cmd, addr, sample_al);

  dac_ad56x3_sclk_timer #(
    .SCLK_DIV (SCLK_DIV)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .start (load),
    .run   (state == SHIFT),
    .fall  (fall),
    .rise  (rise),
    .last  (last)
  );

  // Next-state and next-output decode; din only moves when SCLK goes (or starts) high.
  always_comb begin
    state_nxt = state;
    sync_nxt  = syncN;
    sclk_nxt  = sclk;
    din_nxt   = din;
    rdy_nxt   = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        rdy_nxt = 1'b1;
        if (accept) begin
          state_nxt = SHIFT;
          sync_nxt  = 1'b0;
          sclk_nxt  = 1'b1;
          din_nxt   = frame_word[FRAME_BITS-1];
          load      = 1'b1;
          rdy_nxt   = 1'b0;
        end
      end
      SHIFT: begin
        if (fall) sclk_nxt = 1'b0;
        if (rise) begin
          sclk_nxt = 1'b1;
          if (last) begin
            state_nxt = GAP;
            sync_nxt  = 1'b1;
            din_nxt   = 1'b0;
          end else begin
            din_nxt = shreg[FRAME_BITS-2];
            shift   = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          state_nxt = IDLE;
          rdy_nxt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and pin registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      syncN   <= 1'b1;
      sclk    <= 1'b1;
      din     <= 1'b0;
      asiRdy  <= 1'b0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      syncN   <= sync_nxt;
      sclk    <= sclk_nxt;
      din     <= din_nxt;
      asiRdy  <= rdy_nxt;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

  // Frame shift register: loaded at accept, shifted once per SCLK rise.
  always_ff @(posedge clk) begin
    if (load)       shreg <= frame_word;
    else if (shift) shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
  end

endmodule

// File: doc/dac_ad56x3_spi.md
# dac_ad56x3_spi

Avalon-ST sink that accepts per-channel DAC samples and serialises each one as a 24-bit SPI write frame to an AD5623/AD5643/AD5663 dual DAC. It sits between a sample source, such as the saw test generator or a DSP chain, and the DAC pins. It owns SYNC, SCLK and DIN timing. Channel 0 maps to DAC A and channel 1 to DAC B.

## Interface
Parameters:
- DATA_WIDTH, 14: sample width; legal values are 12, 14 and 16 (elaboration error otherwise).
- SCLK_DIV, 2: number of clk cycles per SCLK half-period, ≥1; SCLK = clk/(2·SCLK_DIV).
- GAP_CYCLES, 2: number of clk cycles syncN stays high between frames, ≥1.
- SIMULT_UPDATE, 1: 1 means ch0 uses cmd 000 (write input reg) and ch1 uses cmd 010 (write, update all); 0 means both channels use cmd 011 (write and update n).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- asiValid  in  1  sample valid.
- asiChannel  in  1  0 selects DAC A, 1 selects DAC B.
- asiData  in  DATA_WIDTH  unsigned sample.
- asiRdy  out  1  sink ready; ready latency 0.
- syncN  out  1  DAC SYNC, active low.
- sclk  out  1  DAC SCLK; idles high.
- din  out  1  DAC DIN, MSB first.

## Operation
- Handshake:
  - A transfer occurs on a clk edge where asiValid & asiRdy are both 1.
  - asiValid while asiRdy=0 is ignored; the source holds its data, and holding is not an error.
- Frame word, 24 bits:
  - [23:22] = 00.
  - [21:19] = cmd.
  - [18:16] = addr: 000 for channel 0, 001 for channel 1.
  - [15:0] = asiData << (16−DATA_WIDTH), zero-filled LSBs.
  - The word is latched into the shift register at accept.
- FSM:
  - IDLE (asiRdy=1) → SHIFT on accept.
  - SHIFT → GAP after the low phase of the 24th SCLK period.
  - GAP → IDLE after GAP_CYCLES.
  - asiRdy=0 in SHIFT and GAP.
- Bit timing:
  - din changes only while sclk is high, at frame start or on a rising edge.
  - The DAC samples din on the sclk falling edge.
- Reset values:
  - Under reset: syncN=1, sclk=1, din=0, asiRdy=0, state=IDLE.
  - asiRdy goes 1 on the first clk edge after release.
- Reset mid-frame:
  - Outputs return to their reset values immediately (asynchronous).
  - The DAC sees syncN rise before the 24th falling edge and discards the frame. No partial write reaches the DAC.

## Timing
- Accept at edge t0.
- From t0+1: syncN=0, sclk=1, din=bit23.
- Falling edge k (k=0..23) occurs at t0+1+SCLK_DIV+k·2·SCLK_DIV. Bit 23−k is stable for SCLK_DIV cycles before it.
- At t0+1+48·SCLK_DIV: syncN=1, sclk=1, din=0.
- asiRdy=1 at t0+1+48·SCLK_DIV+GAP_CYCLES.
- Defaults: syncN low for 96 cycles; asiRdy returns at t0+99; sustained throughput is one sample per 99 clk.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Package dacAd56x3Pkg holds:
  - FRAME_BITS=24.
  - Command constants: CMD_WR_N=000, CMD_WR_UPD_ALL=010, CMD_WR_UPD_N=011.
  - Address constants: ADDR_A=001 is wrong, so use ADDR_A=000 and ADDR_B=001.
  - The state enum {IDLE, SHIFT, GAP}.
- One sub-module, dac_ad56x3_sclk_timer:
  - Half-period counter plus bit counter (0..23).
  - Emits fall, rise and last pulses to the FSM.

## Test plan
Unless a scenario states otherwise, the bench uses DATA_WIDTH=14, SCLK_DIV=2, GAP_CYCLES=2, SIMULT_UPDATE=1, with an AD56x3 behavioural model.
1. Reset: hold reset=0 → syncN=1, sclk=1, din=0, asiRdy=0; release → asiRdy=1 one edge later.
2. ch0, data 14'h2ABC:
   - Model captures 24'h00AAF0 on exactly 24 falling edges.
   - syncN is low for 96 cycles.
   - asiRdy returns at t0+99.
   - DAC A input register = 0x2ABC, output unchanged.
3. ch1, data 14'h3FFF:
   - Frame 24'h11FFFC.
   - Both DAC outputs update together; A keeps 0x2ABC and B becomes 0x3FFF.
4. Saw generator drives ch0 then ch1 back-to-back:
   - ch1 valid is held while asiRdy=0 and is accepted exactly at t0+99, data unchanged.
   - No sample is lost or duplicated over 1000 pairs.
5. reset=0 at t0+40:
   - syncN rises the same cycle.
   - Fewer than 24 falling edges are seen and the model registers are unchanged.
   - The next frame after release completes correctly.
6. SIMULT_UPDATE=0, ch0, data 0 → frame 24'h180000; DAC A output updates immediately.
